mem_port_arbiter: RTL and testbench

- Shares one 32-bit memory port between two requesters: port 0 is instruction fetch and port 1 is data load/store.
- Owns the select line of the port's 2:1 address/write-data mux and sequences each access through a fixed-latency memory.
- Arbitration is round-robin by default, so neither requester starves.
- Sits between the processor's fetch/execute stages and the unified memory.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/arb_rr_pick2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 88 ++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding,
// default widths and the latency counter width.
package mem_port_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int CNT_W      = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/arb_rr_pick2.sv
// Two-way winner pick. Round-robin on a tie by default;
// ARB_FIXED_PRIO_EN makes port 1 (data) always win a tie.
module arb_rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic valid,
    output logic gnt
);

    assign valid = req0 | req1;

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_gnt;
    assign gnt = req1;
`else
    assign gnt = (req0 & req1) ? ~last_gnt : req1;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch (0) and data (1).
// Tie policy selected by ARB_FIXED_PRIO_EN inside arb_rr_pick2.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we0,
    input  logic              we1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              gnt_sel
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_gnt;
    logic             pick_valid;
    logic             pick_gnt;

    arb_rr_pick2 u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .valid    (pick_valid),
        .gnt      (pick_gnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (MEM_LAT == 1) ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt <= CNT_W'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Select is frozen from ISSUE through DONE; only IDLE re-arbitrates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            gnt_sel  <= 1'b0;
            last_gnt <= 1'b1;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && pick_valid)
                gnt_sel <= pick_gnt;
            if (state == S_ISSUE)
                cnt <= CNT_LOAD;
            else if (state == S_WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == S_DONE)
                last_gnt <= gnt_sel;
        end
    end

    assign mem_en = (state == S_ISSUE);
    assign ack0   = (state == S_DONE) && !gnt_sel;
    assign ack1   = (state == S_DONE) && gnt_sel;

    assign mem_addr  = gnt_sel ? addr1  : addr0;
    assign mem_wdata = gnt_sel ? wdata1 : wdata0;
    assign mem_we    = gnt_sel ? we1    : we0;
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (optionally with ARB_FIXED_PRIO_EN).
// Transaction-level reference model plus directed corner sequences.
module tb_mem_port_arbiter;

    localparam int L = 2;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, mem_en, mem_we, gnt_sel;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] rd_q = '0;

    logic        req0b = 1'b0;
    logic [31:0] addr0b = '0;
    logic        ack0b, ack1b, mem_enb, mem_web, gnt_selb;
    logic [31:0] rdatab, mem_addrb, mem_wdatab;
    logic [31:0] mem_rdatab;

    logic        p_r0 = 1'b0, p_r1 = 1'b0, p_last = 1'b0;
    logic        p_valid, p_gnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Fixed-latency memory: data for the issued address appears after mem_en.
    always @(posedge clk) if (mem_en) rd_q <= rom(mem_addr);
    assign mem_rdata  = rd_q;
    assign mem_rdatab = 32'hC0DE_0001;

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(L)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .gnt_sel(gnt_sel)
    );

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0b), .req1(1'b0),
        .addr0(addr0b), .addr1(32'h0),
        .wdata0(32'h0), .wdata1(32'h0),
        .we0(1'b0), .we1(1'b0),
        .ack0(ack0b), .ack1(ack1b), .rdata(rdatab),
        .mem_en(mem_enb), .mem_we(mem_web),
        .mem_addr(mem_addrb), .mem_wdata(mem_wdatab),
        .mem_rdata(mem_rdatab), .gnt_sel(gnt_selb)
    );

    arb_rr_pick2 u_pick_tb (
        .req0(p_r0), .req1(p_r1), .last_gnt(p_last),
        .valid(p_valid), .gnt(p_gnt)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Arbitration rule stated directly: lone requester wins, tie by policy.
    function automatic int exp_pick(input bit r0, input bit r1, input bit last);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (FP) return 1;
        return last ? 0 : 1;
    endfunction

    // Reference model: one outstanding transaction with its issue/ack cycles.
    bit          m_have = 1'b0, m_last = 1'b1, m_gnt = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;
    int          m_iss = 0, m_ack = 0, m_free = 0;
    int          n_en = 0;
    logic [31:0] last_en_addr = '0;

    task automatic step();
        int p;
        bit e_en, e_ack;
        if (!rst_n) begin
            m_have = 1'b0; m_last = 1'b1; m_gnt = 1'b0; m_free = cyc + 1;
        end else if (m_have && cyc == m_ack) begin
            m_have = 1'b0; m_last = m_gnt; m_free = cyc + 1;
        end else if (!m_have && cyc >= m_free && (req0 || req1)) begin
            p = exp_pick(req0, req1, m_last);
            m_gnt   = p[0];
            m_have  = 1'b1;
            m_iss   = cyc + 1;
            m_ack   = cyc + 1 + L;
            m_addr  = m_gnt ? addr1 : addr0;
            m_we    = m_gnt ? we1 : we0;
            m_wdata = m_gnt ? wdata1 : wdata0;
            m_rd    = rom(m_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        e_en  = m_have && cyc == m_iss;
        e_ack = m_have && cyc == m_ack;
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("ack0", 32'(ack0), 32'(e_ack && !m_gnt));
        chk("ack1", 32'(ack1), 32'(e_ack && m_gnt));
        chk("gnt_sel", 32'(gnt_sel), 32'(m_gnt));
        if (e_en) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", 32'(mem_we), 32'(m_we));
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (e_ack && !m_we) chk("rdata", rdata, m_rd);
        if (mem_en) begin
            n_en++;
            last_en_addr = mem_addr;
        end
    endtask

    task automatic wait_ack(input bit p, input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc && at < 0; i++) begin
            step();
            if (p ? ack1 : ack0) at = cyc;
        end
        n_chk++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL ack%0d_timeout: none within %0d cycles", p, maxc);
        end
    endtask

    function automatic logic [31:0] raddr();
        return 32'h40 + 32'($urandom_range(0, 15)) * 4;
    endfunction

    typedef struct packed {
        bit r0; bit r1; bit last; bit valid; bit gnt;
    } pv_t;

    pv_t tbl [8];
    int  acks_p [$];
    int  acks_c [$];

    initial begin
        int t0, at, k, na, en_at, ack_at;
        logic [31:0] rd_at, addr_at;

        tbl[0] = '{0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 0, 0};
        tbl[2] = '{0, 1, 0, 1, 1};
        tbl[3] = '{0, 1, 1, 1, 1};
        tbl[4] = '{1, 0, 0, 1, 0};
        tbl[5] = '{1, 0, 1, 1, 0};
        tbl[6] = '{1, 1, 0, 1, 1};
        tbl[7] = '{1, 1, 1, 1, FP};
        for (int i = 0; i < 8; i++) begin
            p_r0 = tbl[i].r0; p_r1 = tbl[i].r1; p_last = tbl[i].last;
            #1;
            chk($sformatf("pick_valid[%0d]", i), 32'(p_valid), 32'(tbl[i].valid));
            if (tbl[i].valid)
                chk($sformatf("pick_gnt[%0d]", i), 32'(p_gnt), 32'(tbl[i].gnt));
        end

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Single read from port 0
        req0 = 1'b1; addr0 = 32'h40; we0 = 1'b0;
        t0 = cyc;
        wait_ack(1'b0, 10, at);
        chk("t1_lat", 32'(at - t0), 32'(1 + L));
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_en_addr", last_en_addr, 32'h40);
        req0 = 1'b0;

        // Both requesters held continuously
        req0 = 1'b1; addr0 = 32'h200; we0 = 1'b0;
        req1 = 1'b1; addr1 = 32'h300; we1 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step();
            if (ack0 || ack1) begin
                acks_p.push_back(int'(ack1));
                acks_c.push_back(cyc);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (L + 3) step();
        chk("t2_nacks", 32'(acks_p.size()), 32'd4);
        for (int i = 0; i < acks_p.size(); i++) begin
            chk("t2_port", 32'(acks_p[i]), FP ? 32'd1 : 32'((i % 2 == 0) ? 1 : 0));
            if (i > 0) chk("t2_gap", 32'(acks_c[i] - acks_c[i-1]), 32'(L + 2));
        end

        // Port 1 write
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h100; wdata1 = 32'h1234_5678;
        k = 0;
        while (!mem_en && k < 6) begin step(); k++; end
        chk("t3_en", 32'(mem_en), 32'd1);
        chk("t3_we", 32'(mem_we), 32'd1);
        chk("t3_addr", mem_addr, 32'h100);
        chk("t3_wdata", mem_wdata, 32'h1234_5678);
        chk("t3_gnt", 32'(gnt_sel), 32'd1);
        wait_ack(1'b1, 6, at);
        req1 = 1'b0; we1 = 1'b0;

        // Port 0 arrives mid-transaction and changes its address
        req1 = 1'b1; addr1 = 32'h180;
        k = 0;
        while (!mem_en && k < 6) begin step(); k++; end
        req0 = 1'b1; addr0 = 32'h44; we0 = 1'b0;
        n_en = 0;
        step();
        addr0 = 32'h48;
        chk("t4_inflight_addr", mem_addr, 32'h180);
        wait_ack(1'b1, 6, at);
        chk("t4_no_extra_en", 32'(n_en), 32'd0);
        req1 = 1'b0;
        wait_ack(1'b0, 8, at);
        chk("t4_served_addr", last_en_addr, 32'h48);
        req0 = 1'b0;

        // Reset while waiting on memory
        req0 = 1'b1; addr0 = 32'h60;
        k = 0;
        while (!mem_en && k < 6) begin step(); k++; end
        req0 = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_en_after_rst", 32'(mem_en), 32'd0);
        na = 0;
        repeat (4) begin step(); na += int'(ack0) + int'(ack1); end
        chk("t5_no_ack", 32'(na), 32'd0);
        req0 = 1'b1; addr0 = 32'h64;
        t0 = cyc;
        wait_ack(1'b0, 10, at);
        chk("t5_lat", 32'(at - t0), 32'(1 + L));
        chk("t5_rdata", rdata, rom(32'h64));
        req0 = 1'b0;

        // Single-cycle latency instance
        req0b = 1'b1; addr0b = 32'h80;
        t0 = cyc; en_at = -1; ack_at = -1;
        rd_at = '0; addr_at = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_enb && en_at < 0) begin en_at = cyc; addr_at = mem_addrb; end
            if (ack0b && ack_at < 0) begin ack_at = cyc; rd_at = rdatab; req0b = 1'b0; end
        end
        chk("t6_en_lat", 32'(en_at - t0), 32'd1);
        chk("t6_ack_lat", 32'(ack_at - t0), 32'd2);
        chk("t6_addr", addr_at, 32'h80);
        chk("t6_rdata", rd_at, 32'hC0DE_0001);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            if (req0) begin
                if (ack0) req0 = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 31) == 0) req0 = 1'b0;
            end else if (!(m_have && !m_gnt) && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1; addr0 = raddr();
                we0 = 1'($urandom_range(0, 1)); wdata0 = $urandom;
            end
            if (req1) begin
                if (ack1) req1 = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 31) == 0) req1 = 1'b0;
            end else if (!(m_have && m_gnt) && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1; addr1 = raddr();
                we1 = 1'($urandom_range(0, 1)); wdata1 = $urandom;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (L + 4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
